// File: rtl/manager_rx_fsm.sv
// Receive-side frame manager: assembles SYNC/ADDR/DATA byte frames from the
// RS232 receiver, delivers address/data pairs and drops stalled partial frames.
module manager_rx_fsm #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         CNT_W          = 16
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic [7:0] RS_DATAOUT,
  input  logic       RS_TRG_READ,
  output logic [7:0] addr_rx,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    WAIT_ADDR = 2'd2,
    WAIT_DATA = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic [7:0]       fcnt_q, fcnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    fcnt_d   = fcnt_q;

    unique case (state_q)
      IDLE: state_d = WAIT_SYNC;

      WAIT_SYNC: begin
        if (RS_TRG_READ && (RS_DATAOUT == SYNC_BYTE)) begin
          state_d = WAIT_ADDR;
          cnt_d   = '0;
        end
      end

      WAIT_ADDR: begin
        if (RS_TRG_READ) begin
          shadow_d = RS_DATAOUT;
          cnt_d    = '0;
          state_d  = WAIT_DATA;
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_SYNC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_DATA: begin
        // A strobe on the timeout edge still wins and completes the frame.
        if (RS_TRG_READ) begin
          addr_d  = shadow_q;
          data_d  = RS_DATAOUT;
          valid_d = 1'b1;
          fcnt_d  = fcnt_q + 8'd1;
          cnt_d   = '0;
          state_d = WAIT_SYNC;
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_SYNC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign addr_rx   = addr_q;
  assign data_rx   = data_q;
  assign rx_valid  = valid_q;
  assign rx_error  = error_q;
  assign frame_cnt = fcnt_q;
  assign rx_busy   = (state_q == WAIT_ADDR) || (state_q == WAIT_DATA);

endmodule

// File: tb/tb_manager_rx_fsm.sv
// Randomized scoreboard bench for manager_rx_fsm: a frame-buffer reference
// model predicts pulses and output values; a negedge monitor compares them.
module tb_manager_rx_fsm;

  localparam int         T    = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dout;
  logic       trg;
  logic [7:0] addr_rx, data_rx, frame_cnt;
  logic       rx_valid, rx_error, rx_busy;

  manager_rx_fsm #(
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(T),
    .CNT_W         (16)
  ) dut (
    .CLK_50MHZ  (clk),
    .RST        (rst),
    .RS_DATAOUT (dout),
    .RS_TRG_READ(trg),
    .addr_rx    (addr_rx),
    .data_rx    (data_rx),
    .rx_valid   (rx_valid),
    .rx_error   (rx_error),
    .rx_busy    (rx_busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pulse: kind and the edge after which it must be visible.
  typedef struct {
    bit          is_err;
    int unsigned edge_no;
  } ev_t;
  ev_t exp_q[$];

  // Reference model: bytes of the frame collected so far, plus delivered values.
  logic [7:0]  frame[$];
  int unsigned edge_n   = 0;
  int unsigned last_acc = 0;
  bit          settling = 1'b0;
  logic [7:0]  exp_addr = 8'h00, exp_data = 8'h00, exp_cnt = 8'h00;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      frame.delete();
      settling = 1'b1;
      exp_addr = 8'h00;
      exp_data = 8'h00;
      exp_cnt  = 8'h00;
    end else if (settling) begin
      settling = 1'b0;
    end else if (trg) begin
      if (frame.size() == 0) begin
        if (dout == SYNC) begin
          frame.push_back(dout);
          last_acc = edge_n;
        end
      end else if (frame.size() == 1) begin
        frame.push_back(dout);
        last_acc = edge_n;
      end else begin
        exp_addr = frame[1];
        exp_data = dout;
        exp_cnt  = exp_cnt + 8'd1;
        exp_q.push_back('{is_err: 1'b0, edge_no: edge_n});
        frame.delete();
      end
    end else if (frame.size() > 0 && (edge_n - last_acc) == T) begin
      exp_q.push_back('{is_err: 1'b1, edge_no: edge_n});
      frame.delete();
    end
  end

  always @(negedge clk) begin
    if (edge_n > 0) begin
      check("valid_error_exclusive", 32'(rx_valid & rx_error), 32'd0);
      check("rx_busy", 32'(rx_busy), 32'(frame.size() > 0));
      check("addr_rx", 32'(addr_rx), 32'(exp_addr));
      check("data_rx", 32'(data_rx), 32'(exp_data));
      check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      if (rx_valid || rx_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'({rx_valid, rx_error}), 32'd0);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          check("pulse_kind_is_error", 32'(rx_error), 32'(ev.is_err));
          check("pulse_edge", edge_n, ev.edge_no);
        end
      end else if (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
        check("missing_pulse", 32'(rx_valid | rx_error), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic s, input logic [7:0] d, input logic r);
    trg  = s;
    dout = d;
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a, d;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    send(SYNC);                 // lands in IDLE and must be ignored
    send(8'h12); send(8'h34);   // garbage while hunting for SYNC
    idle(2);

    // Basic frame with strobes three clocks apart
    send(SYNC); idle(2); send(8'h12); idle(2); send(8'h34); idle(3);

    // Garbage then a frame
    send(8'h00); send(8'hFF); send(8'h5A);
    send(SYNC); send(8'h01); send(8'h02); idle(2);

    // Timeout after SYNC, then a normal frame
    send(SYNC); idle(T + 4);
    send(SYNC); send(8'h07); send(8'h08); idle(2);
    // DATA exactly on the edge the timeout would fire
    send(SYNC); send(8'h07); idle(T - 1); send(8'h08); idle(2);
    // Timeout while waiting for DATA
    send(SYNC); send(8'h07); idle(T + 3);

    // Back-to-back frames and SYNC accepted as an address
    send(SYNC); send(8'h10); send(8'h20);
    send(SYNC); send(8'h11); send(8'h21);
    send(SYNC); send(SYNC); send(8'h33); idle(2);

    // Reset mid-frame, strobe during IDLE, then a full frame
    send(SYNC); send(8'h12);
    step(1'b0, 8'h00, 1'b1);
    send(SYNC);
    send(8'h56);
    send(SYNC); send(8'h9A); send(8'hBC); idle(2);

    // 256 frames from reset: frame counter wraps to zero
    step(1'b0, 8'h00, 1'b1);
    idle(1);
    a = 8'h00;
    d = 8'h00;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 8'hA4)));
      a = 8'($urandom);
      d = 8'($urandom);
      send(SYNC);
      idle($urandom_range(0, 2));
      send(a);
      idle($urandom_range(0, 2));
      send(d);
      idle($urandom_range(0, 1));
    end
    idle(3);
    check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
    check("addr_hold_last", 32'(addr_rx), 32'(a));
    check("data_hold_last", 32'(data_rx), 32'(d));

    // Random byte stream with occasional long silences and resets
    for (int i = 0; i < 800; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2) step(1'b0, 8'h00, 1'b1);
      else if (r < 6) idle($urandom_range(T - 2, T + 2));
      else if (r < 50) send(($urandom_range(0, 2) == 0) ? SYNC : 8'($urandom));
      else idle(1);
    end
    idle(T + 4);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
